// File: rtl/contador_secuenciador.sv
// Job sequencer for the 16-bit mode counter: load, count until N RCO wraps or abort, then report.
// Latency: accept at edge N, counter loads at N+1, first count at N+2; done one cycle after final RCO/abort.
// Backpressure: cmd_ready only in IDLE; commands presented outside IDLE are dropped, not queued.
module contador_secuenciador #(
    parameter int WIDTH  = 16,
    parameter int WRAP_W = 8
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_modo,
    input  logic [WIDTH-1:0]  cmd_load,
    input  logic [WRAP_W-1:0] cmd_wraps,
    input  logic              abort,
    output logic              enb,
    output logic [1:0]        modo,
    output logic [WIDTH-1:0]  D,
    input  logic [WIDTH-1:0]  Q,
    input  logic              RCO,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic [WIDTH-1:0]  q_final
);

    typedef enum logic [1:0] {IDLE, LOAD, COUNT, DONE} state_t;

    state_t             state, state_nxt;
    logic [1:0]         job_modo;
    logic [WRAP_W-1:0]  job_wraps;
    logic [WRAP_W-1:0]  wrap_inc;

    logic               enb_nxt, busy_nxt, done_nxt, ready_nxt;
    logic [1:0]         modo_nxt;
    logic [WIDTH-1:0]   d_nxt;

    assign wrap_inc = (wrap_cnt == '1) ? wrap_cnt : wrap_cnt + 1'b1;

    // Counter-facing outputs are computed from the next state so they leave flops.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state     <= IDLE;
            enb       <= 1'b0;
            modo      <= 2'b00;
            D         <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cmd_ready <= 1'b1;
        end else begin
            state     <= state_nxt;
            enb       <= enb_nxt;
            modo      <= modo_nxt;
            D         <= d_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            cmd_ready <= ready_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_valid) state_nxt = LOAD;
            LOAD:    if (job_wraps == '0 || abort) state_nxt = DONE;
                     else state_nxt = COUNT;
            COUNT:   if (abort || (RCO && wrap_inc == job_wraps)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // LOAD is only entered from IDLE, so the preload comes straight off the command bus.
    always_comb begin
        enb_nxt   = 1'b0;
        modo_nxt  = 2'b00;
        d_nxt     = '0;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        ready_nxt = 1'b0;
        case (state_nxt)
            IDLE:  ready_nxt = 1'b1;
            LOAD: begin
                enb_nxt  = 1'b1;
                modo_nxt = 2'b11;
                d_nxt    = cmd_load;
                busy_nxt = 1'b1;
            end
            COUNT: begin
                enb_nxt  = 1'b1;
                modo_nxt = job_modo;
                busy_nxt = 1'b1;
            end
            DONE:    done_nxt = 1'b1;
            default: ready_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            job_modo  <= 2'b00;
            job_wraps <= '0;
            wrap_cnt  <= '0;
            aborted   <= 1'b0;
            q_final   <= '0;
        end else begin
            if (state == IDLE && cmd_valid) begin
                job_modo  <= (cmd_modo == 2'b11) ? 2'b00 : cmd_modo;
                job_wraps <= cmd_wraps;
                wrap_cnt  <= '0;
                aborted   <= 1'b0;
            end
            // A final RCO coinciding with abort still counts; abort decides the ending.
            if (state == COUNT && RCO)
                wrap_cnt <= wrap_inc;
            if ((state == LOAD || state == COUNT) && abort)
                aborted <= 1'b1;
            if (state == DONE)
                q_final <= Q;
        end
    end

endmodule

// File: tb/tb_contador_secuenciador.sv
// Bench for contador_secuenciador: behavioural mode counter plus directed and random jobs
// checked against an arithmetic job-outcome model.
module tb_contador_secuenciador;

    logic        clk = 1'b0;
    logic        reset_L;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_modo;
    logic [15:0] cmd_load;
    logic [7:0]  cmd_wraps;
    logic        abort;
    logic        enb;
    logic [1:0]  modo;
    logic [15:0] D;
    logic [15:0] Q;
    logic        RCO;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [7:0]  wrap_cnt;
    logic [15:0] q_final;

    int n_cmp = 0;
    int n_bad = 0;

    // Counter model; fast_fwd jumps from FFFF to 0002 when counting down to shorten full wraps.
    logic [15:0] ctr = 16'h0000;
    bit          fast_fwd = 1'b0;

    always #5 clk = ~clk;

    assign Q   = ctr;
    assign RCO = enb && ((modo == 2'b00 && ctr == 16'hFFFF) ||
                         (modo == 2'b01 && ctr == 16'h0000) ||
                         (modo == 2'b10 && ctr >= 16'hFFFD));

    always @(posedge clk) begin
        if (enb) begin
            case (modo)
                2'b00:   ctr <= ctr + 16'd1;
                2'b01:   ctr <= (fast_fwd && ctr == 16'hFFFF) ? 16'h0002 : ctr - 16'd1;
                2'b10:   ctr <= ctr + 16'd3;
                default: ctr <= D;
            endcase
        end
    end

    contador_secuenciador #(.WIDTH(16), .WRAP_W(8)) dut (
        .clk(clk), .reset_L(reset_L),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_modo(cmd_modo), .cmd_load(cmd_load), .cmd_wraps(cmd_wraps),
        .abort(abort), .enb(enb), .modo(modo), .D(D), .Q(Q), .RCO(RCO),
        .busy(busy), .done(done), .aborted(aborted),
        .wrap_cnt(wrap_cnt), .q_final(q_final)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Outcome of a job from the counting rules: done cycle index (LOAD = 0), wraps, final Q, aborted.
    function automatic void predict(input logic [1:0] m, input logic [15:0] ld, input logic [7:0] wr,
                                    input int ab_at, output int dk, output logic [7:0] wc,
                                    output logic [15:0] qf, output bit ab);
        int q, qn, nx, step;
        bit r;
        step = (m == 2'b10) ? 3 : (m == 2'b01) ? -1 : 1;
        q  = int'(ld);
        wc = 8'd0;
        ab = 1'b0;
        dk = -1;
        qf = ld;
        if (wr == 8'd0 || ab_at == 0) begin
            dk = 1;
            ab = (ab_at == 0);
            return;
        end
        for (int k = 1; k < 200; k++) begin
            nx = q + step;
            r  = (nx < 0) || (nx > 65535);
            qn = (nx + 65536) % 65536;
            if (r) wc = wc + 8'd1;
            if (k == ab_at || (r && wc == wr)) begin
                ab = (k == ab_at);
                dk = k + 1;
                qf = qn[15:0];
                return;
            end
            q = qn;
        end
    endfunction

    // Entered and left at a falling edge inside an IDLE cycle.
    task automatic run_job(input string tag, input logic [1:0] m, input logic [15:0] ld,
                           input logic [7:0] wr, input int ab_at, input bit hold,
                           input int exp_k, input logic [7:0] exp_wc, input logic [15:0] exp_qf,
                           input bit exp_ab);
        int k;
        bit fin;
        logic [1:0] em;
        em = (m == 2'b11) ? 2'b00 : m;
        cmd_modo  = m;
        cmd_load  = ld;
        cmd_wraps = wr;
        cmd_valid = 1'b1;
        check({tag, "/ready_idle"}, 32'(cmd_ready), 32'd1);
        @(negedge clk);
        if (!hold) cmd_valid = 1'b0;
        abort = (ab_at == 0);
        check({tag, "/load_ctl"}, 32'({enb, modo, busy, cmd_ready, aborted}), 32'(6'b1_11_1_0_0));
        check({tag, "/load_d"}, 32'(D), 32'(ld));
        check({tag, "/load_wc"}, 32'(wrap_cnt), 32'd0);
        k = 0;
        fin = 1'b0;
        while (!fin && k < 200) begin
            @(negedge clk);
            k++;
            abort = (k == ab_at);
            if (done) begin
                fin = 1'b1;
                check({tag, "/done_cycle"}, 32'(k), 32'(exp_k));
                check({tag, "/done_ctl"}, 32'({enb, busy, cmd_ready}), 32'd0);
                check({tag, "/done_aborted"}, 32'(aborted), 32'(exp_ab));
                check({tag, "/done_wc"}, 32'(wrap_cnt), 32'(exp_wc));
            end else begin
                check({tag, "/count_ctl"}, 32'({enb, modo, busy, cmd_ready}), 32'({1'b1, em, 1'b1, 1'b0}));
                check({tag, "/count_d"}, 32'(D), 32'd0);
            end
        end
        abort = 1'b0;
        check({tag, "/done_seen"}, 32'(fin), 32'd1);
        @(negedge clk);
        check({tag, "/post_ctl"}, 32'({done, busy, cmd_ready}), 32'(3'b001));
        check({tag, "/post_qfinal"}, 32'(q_final), 32'(exp_qf));
        check({tag, "/post_wc"}, 32'(wrap_cnt), 32'(exp_wc));
        check({tag, "/post_aborted"}, 32'(aborted), 32'(exp_ab));
    endtask

    initial begin
        logic [1:0]  rm;
        logic [15:0] rl;
        logic [7:0]  rw, pwc;
        logic [15:0] pqf;
        int          rab, pdk, tmp;
        bit          pab;

        reset_L = 1'b1; cmd_valid = 1'b0; cmd_modo = 2'b00;
        cmd_load = 16'h0000; cmd_wraps = 8'd0; abort = 1'b0;
        #1 reset_L = 1'b0;
        repeat (2) @(negedge clk);
        check("reset/ctl", 32'({enb, busy, done, aborted, cmd_ready}), 32'(5'b00001));
        check("reset/modo_d", 32'({modo, D}), 32'd0);
        check("reset/wc_qf", 32'({wrap_cnt, q_final}), 32'd0);
        reset_L = 1'b1;
        @(negedge clk);

        run_job("up_fffd",   2'b00, 16'hFFFD, 8'd1, -1, 1'b0, 4, 8'd1, 16'h0000, 1'b0);
        fast_fwd = 1'b1;
        run_job("down_3",    2'b01, 16'h0001, 8'd3, -1, 1'b0, 11, 8'd3, 16'hFFFF, 1'b0);
        fast_fwd = 1'b0;
        run_job("load_only", 2'b00, 16'h1234, 8'd0, -1, 1'b0, 1, 8'd0, 16'h1234, 1'b0);
        run_job("abort5",    2'b00, 16'h0000, 8'd2, 5, 1'b0, 6, 8'd0, 16'h0005, 1'b1);
        run_job("modo11",    2'b11, 16'hFFFF, 8'd1, -1, 1'b0, 2, 8'd1, 16'h0000, 1'b0);
        run_job("up3",       2'b10, 16'hFFFA, 8'd1, -1, 1'b0, 3, 8'd1, 16'h0000, 1'b0);
        run_job("abort_rco", 2'b00, 16'hFFFF, 8'd1, 1, 1'b0, 2, 8'd1, 16'h0000, 1'b1);
        run_job("abort_ld",  2'b00, 16'h0100, 8'd2, 0, 1'b0, 1, 8'd0, 16'h0100, 1'b1);

        // cmd_valid stays high across job A; B must be taken only in the IDLE cycle after done.
        run_job("hold_a",    2'b00, 16'hFFFE, 8'd1, -1, 1'b1, 3, 8'd1, 16'h0000, 1'b0);
        run_job("hold_b",    2'b00, 16'h1234, 8'd0, -1, 1'b0, 1, 8'd0, 16'h1234, 1'b0);
        @(negedge clk);
        check("hold/no_reaccept", 32'({busy, cmd_ready}), 32'(2'b01));

        for (int j = 0; j < 24; j++) begin
            rm = 2'($urandom_range(0, 3));
            rw = 8'($urandom_range(0, 1));
            if (rm == 2'b01)      tmp = int'($urandom_range(0, 20));
            else if (rm == 2'b10) tmp = 65535 - int'($urandom_range(0, 40));
            else                  tmp = 65535 - int'($urandom_range(0, 20));
            rl = tmp[15:0];
            rab = (rw != 8'd0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(0, 25)) : -1;
            predict(rm, rl, rw, rab, pdk, pwc, pqf, pab);
            run_job($sformatf("rand%0d", j), rm, rl, rw, rab, 1'b0, pdk, pwc, pqf, pab);
        end

        cmd_modo = 2'b00; cmd_load = 16'h0000; cmd_wraps = 8'd2; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst/busy_before", 32'(busy), 32'd1);
        #2 reset_L = 1'b0;
        #1;
        check("midrst/ctl", 32'({enb, busy, done, aborted, cmd_ready}), 32'(5'b00001));
        check("midrst/modo_d", 32'({modo, D}), 32'd0);
        check("midrst/wc_qf", 32'({wrap_cnt, q_final}), 32'd0);
        @(negedge clk);
        reset_L = 1'b1;
        @(negedge clk);
        check("midrst/idle", 32'({enb, busy, cmd_ready}), 32'(3'b001));
        run_job("after_rst", 2'b00, 16'hFFFE, 8'd1, -1, 1'b0, 3, 8'd1, 16'h0000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
